// File: rtl/multiword_add_sub_ctrl_pkg.sv
// rtl/multiword_add_sub_ctrl_pkg.sv - op and FSM state encodings for the multiword add/sub controller
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multiword_add_sub_ctrl_ripple.sv
// rtl/multiword_add_sub_ctrl_ripple.sv - NUM_BIT ripple add/sub slice; mode=1 inverts b for subtract
module ripple_add_sub_nbit #(
  parameter int NUM_BIT = 8
) (
  input  logic [NUM_BIT-1:0] a,
  input  logic [NUM_BIT-1:0] b,
  input  logic               mode,
  input  logic               cin,
  output logic [NUM_BIT-1:0] sum,
  output logic               cout
);

  logic carry;
  logic b_eff;

  always_comb begin
    sum   = '0;
    carry = cin;
    b_eff = 1'b0;
    for (int i = 0; i < NUM_BIT; i++) begin
      b_eff  = b[i] ^ mode;
      sum[i] = a[i] ^ b_eff ^ carry;
      carry  = (a[i] & b_eff) | (carry & (a[i] ^ b_eff));
    end
    cout = carry;
  end

endmodule

// File: rtl/multiword_add_sub_ctrl.sv
// rtl/multiword_add_sub_ctrl.sv - wide add/sub sequenced word-by-word over one slice, LSW first
// Optional signed-overflow output built only when ADDSUB_OVF_EN is defined.
module multiword_add_sub_ctrl
  import add_sub_pkg::*;
#(
  parameter int NUM_BIT   = 8,
  parameter int NUM_WORDS = 4,
  localparam int W        = NUM_BIT * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

  logic [1:0]         state;
  logic [KW-1:0]      k;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               op_q;
  logic               carry_q;
  logic [NUM_BIT-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_cin;

  // word 0 takes op as carry-in so subtract becomes a + ~b + 1
  assign slice_cin = (k == '0) ? op_q : carry_q;

  ripple_add_sub_nbit #(.NUM_BIT(NUM_BIT)) u_slice (
    .a    (a_q[int'(k)*NUM_BIT +: NUM_BIT]),
    .b    (b_q[int'(k)*NUM_BIT +: NUM_BIT]),
    .mode (op_q),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            k     <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result[int'(k)*NUM_BIT +: NUM_BIT] <= slice_sum;
          carry_q <= slice_cout;
          k       <= k + 1'b1;
          if (k == K_LAST) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);
  assign cout  = carry_q;

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  // last-word sum MSB is result[W-1] as it is being written
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == ST_RUN && k == K_LAST) begin
      ovf_q <= (a_q[W-1] == (b_q[W-1] ^ (op_q == OP_SUB))) &&
               (slice_sum[NUM_BIT-1] != a_q[W-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multiword_add_sub_ctrl.sv
// tb/tb_multiword_add_sub_ctrl.sv - scoreboard bench for multiword_add_sub_ctrl (NUM_BIT=8, NUM_WORDS=4)
module tb_multiword_add_sub_ctrl;

  localparam int NUM_BIT   = 8;
  localparam int NUM_WORDS = 4;
  localparam int W         = NUM_BIT * NUM_WORDS;
  localparam int LAT       = NUM_WORDS + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] result;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  multiword_add_sub_ctrl #(.NUM_BIT(NUM_BIT), .NUM_WORDS(NUM_WORDS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] ye;
    ye = o ? ~y : y;
    s  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, o};
    e.res  = s[W-1:0];
    e.cout = s[W];
`ifdef ADDSUB_OVF_EN
    e.ovf  = (x[W-1] == ye[W-1]) && (s[W-1] != x[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // called just after a negedge; returns one negedge after the accepting edge
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({ready, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags: got ready/busy/done=%b exp 100", {ready, busy, done});
    end
    vectors++;
    if ({result, cout, ovf} !== {{W{1'b0}}, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_data: got result=%h cout=%b ovf=%b exp 0/0/0", result, cout, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_carry;
    int   lat;
    exp_t e;
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001);
    vectors++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL add_busy: got busy=%b ready=%b exp 1/0", busy, ready);
    end
    wait_done(1, lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL add_latency: got %0d exp %0d", lat, LAT);
    end
    e = sb.pop_front();
    vectors++;
    if (result !== e.res || cout !== e.cout || ovf !== e.ovf || result !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL add_carry: got %h c%b o%b exp %h c%b o%b", result, cout, ovf, e.res, e.cout, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[6] = '{32'd5, 32'd12, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [W-1:0] vb[6] = '{32'd12, 32'd5, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8765_4321};
    logic         vo[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(vo[i], va[i], vb[i]);
      wait_done(1, lat);
      e = sb.pop_front();
      vectors++;
      if (lat !== LAT || result !== e.res || cout !== e.cout || ovf !== e.ovf) begin
        miscompares++;
        $display("FAIL vec%0d: got lat=%0d %h c%b o%b exp lat=%0d %h c%b o%b",
                 i, lat, result, cout, ovf, LAT, e.res, e.cout, e.ovf);
      end
      @(negedge clk);
    end
    // fixed anchors independent of the model
    vectors++;
    if (model(1'b1, 32'd5, 32'd12) !== {32'hFFFF_FFF9, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL anchor_sub: model disagrees with 0xFFFFFFF9 c0");
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (result !== e.res || cout !== e.cout || ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_idle: got %h c%b ready=%b done=%b exp %h c%b 1 0", result, cout, ready, done, e.res, e.cout);
    end
  endtask

  task automatic test_ignore_in_run;
    int   lat;
    exp_t e;
    issue(1'b0, 32'h0101_0101, 32'h0202_0202);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat);
    e = sb.pop_front();
    vectors++;
    if (lat !== LAT || result !== e.res || cout !== e.cout || ovf !== e.ovf) begin
      miscompares++;
      $display("FAIL ignore_run: got lat=%0d %h c%b exp lat=%0d %h c%b", lat, result, cout, LAT, e.res, e.cout);
    end
    @(negedge clk);
    repeat (6) begin
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_queued: got done=%b busy=%b exp 0 0", done, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    exp_t e;
    issue(1'b1, 32'h0000_1000, 32'h0000_0001);
    wait_done(1, lat);
    e = sb.pop_front();
    vectors++;
    if (result !== e.res || cout !== e.cout || ovf !== e.ovf) begin
      miscompares++;
      $display("FAIL b2b_first: got %h c%b o%b exp %h c%b o%b", result, cout, ovf, e.res, e.cout, e.ovf);
    end
    issue(1'b0, 32'hFFFF_0000, 32'h0001_FFFF);
    wait_done(1, lat);
    e = sb.pop_front();
    vectors++;
    if (lat !== LAT || result !== e.res || cout !== e.cout || ovf !== e.ovf) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d %h c%b exp lat=%0d %h c%b", lat, result, cout, LAT, e.res, e.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int   lat;
    exp_t e;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({ready, busy, done} !== 3'b100 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_run: got rbd=%b %h c%b o%b exp 100 0 c0 o0", {ready, busy, done}, result, cout, ovf);
    end
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_nodone: got done=%b exp 0", done);
      end
    end
    issue(1'b1, 32'h8000_0000, 32'h0000_0001);
    wait_done(1, lat);
    e = sb.pop_front();
    vectors++;
    if (lat !== LAT || result !== e.res || cout !== e.cout || ovf !== e.ovf) begin
      miscompares++;
      $display("FAIL rst_after: got lat=%0d %h c%b o%b exp lat=%0d %h c%b o%b",
               lat, result, cout, ovf, LAT, e.res, e.cout, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_vectors();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
